bcd_match_timer: RTL and testbench
==================================

# bcd_match_timer

Parametrised multi-digit BCD match timer for the foosball scoreboard. It counts down from a preset to zero, or up from zero to the preset, one step per accepted tick strobe. It supports pause, auto-reload and an optional low-time warning flag. It replaces the fixed two-digit down counter and drives the 7-segment time display and the match-end logic.

## Interface
- DIGITS, 2: number of BCD digits; legal range 1..8.
- AUTO_RELOAD, 0: 1 restarts the count after terminal; 0 saturates at terminal.
- WARN_LEVEL, 10: BCD-encoded threshold for `warn`, DIGITS*4 bits wide. Used only with TIMER_WARN_EN.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; one clock, no other clock domains.
- tick  in  1  one-cycle step strobe, e.g. 1 Hz enable.
- run  in  1  1 = counting; 0 = paused, tick ignored.
- load  in  1  restart strobe.
- up  in  1  direction: 1 = count up, 0 = count down.
- preset  in  4*DIGITS  BCD start value (down) or limit (up); digit 0 in bits [3:0].
- count  out  4*DIGITS  current BCD value, registered.
- tc  out  1  terminal-count flag.
- done  out  1  one-cycle pulse on reaching terminal.
- warn  out  1  low-time warning.

## Operation
- Priority per clock: reset > load > step; step = tick & run.
- Reset: count = 0, done = 0, warn = 0.
- Load:
  - In down mode, count = preset. In up mode, count = 0.
  - Any preset digit > 9 is clamped to 9 on load.
  - Load never pulses `done`.
- Step, down mode:
  - Digit 0 decrements with 0→9 borrow.
  - Digit i decrements only when digits 0..i-1 are all 0.
- Step, up mode:
  - Digit 0 increments with 9→0 carry.
  - Digit i increments only when digits 0..i-1 are all 9.
- Terminal condition:
  - Down mode: count == 0.
  - Up mode: count >= preset, compared as an unsigned BCD magnitude.
  - `tc` is combinational from count, up and preset.
- Step while at terminal:
  - AUTO_RELOAD = 0: count holds and `done` stays 0.
  - AUTO_RELOAD = 1: count reloads (preset for down, 0 for up) and `done` pulses again on the next arrival at terminal.
  - AUTO_RELOAD = 1 with the reload value itself terminal (down with preset = 0, or up with preset = 0): count holds and `done` pulses on every accepted step.
- Step that makes count reach terminal: `done` = 1 for exactly that cycle.
- Changing `up` mid-run takes effect on the next step; count is not modified.
- Changing `preset` mid-run in up mode moves the terminal immediately via `tc`. No retroactive `done` is generated.
- Pause (run = 0): count, tc and warn hold; done = 0.

## Timing
- Latency: step sampled at edge N; count and done update at edge N, visible in cycle N+1.
- `tc` follows count combinationally within the same cycle.
- `done` and `warn` are registered and aligned with the count value that caused them.
- Reset mid-count: count = 0 on the next edge; any pending done is suppressed.
- After reset in down mode, tc = 1 with done = 0.
- Load and tick in the same cycle: load wins and the tick is dropped.
- Back-to-back ticks on consecutive cycles are legal; one step per tick.

## Configuration
- Macro: TIMER_WARN_EN.
- Defined:
  - warn = 1 when down mode, run = 1 and 0 < count <= WARN_LEVEL; registered.
  - warn clears on terminal, load, reset or up = 1.
- Undefined: warn is tied to 0 and no comparator is built. The port remains present.

## Test plan
- Down count, DIGITS=2, preset 8'h12, load, 12 ticks: count steps 12, 11, 10, 09, …, 00. `done` pulses once with count 00 and tc = 1. A 13th tick leaves 00 with no done.
- Up count, DIGITS=3, preset 12'h105, up = 1, load, 105 ticks: carry 099→100 is correct. tc rises at 105 with done. Further ticks hold 105.
- AUTO_RELOAD=1, preset 8'h03, down: ticks give 03, 02, 01, 00 (done), then 03, 02, … `done` period is 4 ticks.
- Priority: load and tick together with preset 8'h45 gives count 45. Run = 0 with 5 ticks leaves count unchanged. Preset 8'hA7 on load gives 97. Reset mid-count gives 00 with done = 0 on the next cycle.
- TIMER_WARN_EN with WARN_LEVEL 8'h10, preset 8'h15, down: warn rises with count 10 and holds through 01. warn falls with count 00. With the macro undefined, warn stays 0 throughout.

Source files
------------

// File: rtl/bcd_match_timer.sv
// bcd_match_timer: multi-digit BCD match timer. It counts down from preset to 0, or up from 0 to preset.
// Latency: a step sampled on edge N is visible in count/done/warn in cycle N+1. tc follows count combinationally.
// Backpressure: none. Every accepted step (tick & run) is consumed in the cycle it is presented.
//
// Ports:
//   clk     - single system clock, rising edge
//   reset   - synchronous, active-high
//   tick    - one-cycle step strobe
//   run     - 1 = counting, 0 = paused (tick ignored)
//   load    - restart strobe (down: count = preset, up: count = 0)
//   up      - direction, 1 = count up, 0 = count down
//   preset  - BCD start value (down) or limit (up), digit 0 in [3:0]
//   count   - registered BCD value
//   tc      - terminal-count flag, combinational from count/up/preset
//   done    - one-cycle pulse on arrival at terminal
//   warn    - low-time warning, registered
//
// Optional feature macro: TIMER_WARN_EN. When it is defined, the warn comparator against WARN_LEVEL is built.
// When it is undefined, warn is tied low and the port is kept.

module bcd_match_timer #(
  parameter int                DIGITS      = 2,
  parameter bit                AUTO_RELOAD = 1'b0,
  parameter logic [4*DIGITS-1:0] WARN_LEVEL = (4*DIGITS)'(16)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                run,
  input  logic                load,
  input  logic                up,
  input  logic [4*DIGITS-1:0] preset,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                done,
  output logic                warn
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] preset_cl;   // preset with every digit clamped to 9
  logic [W-1:0] cnt_inc;     // count + 1 in BCD
  logic [W-1:0] cnt_dec;     // count - 1 in BCD
  logic [W-1:0] reload_val;  // value applied by load or by auto-reload
  logic [W-1:0] nxt;         // count after an accepted step
  logic         nxt_done;    // done value that accompanies nxt
  logic         step;

  // Terminal test shared by tc and the arrival detection. Valid BCD orders the same way as
  // plain binary, so an unsigned compare gives the BCD magnitude compare.
  function automatic logic is_term(input logic [W-1:0] v,
                                   input logic         dir_up,
                                   input logic [W-1:0] lim);
    return dir_up ? (v >= lim) : (v == '0);
  endfunction

  // Out-of-range preset digits are treated as 9. This applies to the loaded value and to
  // the up-mode limit, so an up count can always reach its terminal.
  always_comb begin
    preset_cl = preset;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) begin
        preset_cl[4*i +: 4] = 4'd9;
      end
    end
  end

  // Ripple BCD increment and decrement. A digit moves only when every lower digit is at
  // its wrap value (9 going up, 0 going down).
  always_comb begin
    logic all9;
    logic all0;
    cnt_inc = count;
    cnt_dec = count;
    all9    = 1'b1;
    all0    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (all9) begin
        cnt_inc[4*i +: 4] = (count[4*i +: 4] >= 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
      end
      if (all0) begin
        cnt_dec[4*i +: 4] = (count[4*i +: 4] == 4'd0) ? 4'd9 : count[4*i +: 4] - 4'd1;
      end
      all9 = all9 & (count[4*i +: 4] == 4'd9);
      all0 = all0 & (count[4*i +: 4] == 4'd0);
    end
  end

  assign tc         = is_term(count, up, preset_cl);
  assign step       = tick & run;
  assign reload_val = up ? '0 : preset_cl;

  // Next value for an accepted step.
  // At terminal, the count either holds (no done) or reloads. A reload value that is itself
  // terminal (preset 0) holds the count at 0 and pulses done on every step.
  always_comb begin
    nxt      = count;
    nxt_done = 1'b0;
    if (tc) begin
      if (AUTO_RELOAD) begin
        nxt      = reload_val;
        nxt_done = is_term(reload_val, up, preset_cl);
      end
    end else begin
      nxt      = up ? cnt_inc : cnt_dec;
      nxt_done = is_term(nxt, up, preset_cl);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      // Load wins over a same-cycle tick and never pulses done.
      count <= reload_val;
      done  <= 1'b0;
    end else if (step) begin
      count <= nxt;
      done  <= nxt_done;
    end else begin
      done  <= 1'b0;
    end
  end

`ifdef TIMER_WARN_EN
  // warn is evaluated on the value count takes at this edge, so it lines up with that
  // count. It holds while paused. The zero test makes it clear at the down terminal.
  logic [W-1:0] warn_val;
  assign warn_val = step ? nxt : count;

  always_ff @(posedge clk) begin
    if (reset) begin
      warn <= 1'b0;
    end else if (load || up) begin
      warn <= 1'b0;
    end else if (run) begin
      warn <= (warn_val != '0) && (warn_val <= WARN_LEVEL);
    end
  end
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_match_timer.sv
module tb_bcd_match_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tick, run, load, up;
  logic [7:0]  preset2;
  logic [11:0] preset3;
  logic [7:0]  dn_count, ar_count;
  logic [11:0] up_count;
  logic        dn_tc, dn_done, dn_warn;
  logic        up_tc, up_done, up_warn;
  logic        ar_tc, ar_done, ar_warn;

  bcd_match_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0), .WARN_LEVEL(8'h10)) u_dn (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .load(load), .up(up),
    .preset(preset2), .count(dn_count), .tc(dn_tc), .done(dn_done), .warn(dn_warn));

  bcd_match_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0), .WARN_LEVEL(12'h010)) u_up (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .load(load), .up(up),
    .preset(preset3), .count(up_count), .tc(up_tc), .done(up_done), .warn(up_warn));

  bcd_match_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1), .WARN_LEVEL(8'h10)) u_ar (
    .clk(clk), .reset(reset), .tick(tick), .run(run), .load(load), .up(up),
    .preset(preset2), .count(ar_count), .tc(ar_tc), .done(ar_done), .warn(ar_warn));

  typedef struct {
    int dn_cnt; bit dn_done; bit dn_tc; bit dn_warn;
    int up_cnt; bit up_done; bit up_tc;
    int ar_cnt; bit ar_done; bit ar_tc;
  } exp_t;

  exp_t sb[$];
  int   m_dn = 0, m_up = 0, m_ar = 0;
  bit   m_dn_warn = 0;
  int   errors = 0, checks = 0;

  // Decimal value of a BCD word. Digits above 9 are read as 9, which is how a loaded preset behaves.
  function automatic int bcd2int(input logic [31:0] v, input int digits);
    int r = 0;
    for (int i = digits - 1; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int n);
    logic [31:0] r = '0;
    int m = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic bit mterm(input int c, input bit u, input int p);
    return u ? (c >= p) : (c == 0);
  endfunction

  // Reference behaviour on decimal integers for one clock edge.
  function automatic int mstep(input int cnt, input bit rst, input bit ld, input bit stp,
                               input bit u, input bit ar, input int p, output bit dn);
    int r = cnt;
    dn = 0;
    if (rst) r = 0;
    else if (ld) r = u ? 0 : p;
    else if (stp) begin
      if (mterm(cnt, u, p)) begin
        if (ar) begin
          r  = u ? 0 : p;
          dn = mterm(r, u, p);
        end
      end else begin
        r  = u ? cnt + 1 : cnt - 1;
        dn = mterm(r, u, p);
      end
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, push the expected post-edge state, then step past the edge.
  task automatic drive(input bit rst, input bit tk, input bit rn, input bit ld, input bit u,
                       input logic [7:0] p2, input logic [11:0] p3);
    exp_t e;
    int   pd2, pd3;
    bit   d1, d2, d3;
    reset = rst; tick = tk; run = rn; load = ld; up = u; preset2 = p2; preset3 = p3;
    pd2 = bcd2int({24'h0, p2}, 2);
    pd3 = bcd2int({20'h0, p3}, 3);
    m_dn = mstep(m_dn, rst, ld, tk & rn, u, 1'b0, pd2, d1);
    m_up = mstep(m_up, rst, ld, tk & rn, u, 1'b0, pd3, d2);
    m_ar = mstep(m_ar, rst, ld, tk & rn, u, 1'b1, pd2, d3);
    if (rst || ld || u) m_dn_warn = 0;
    else if (rn) m_dn_warn = (m_dn > 0) && (m_dn <= 10);
    e.dn_cnt = m_dn; e.dn_done = d1; e.dn_tc = mterm(m_dn, u, pd2);
`ifdef TIMER_WARN_EN
    e.dn_warn = m_dn_warn;
`else
    e.dn_warn = 1'b0;
`endif
    e.up_cnt = m_up; e.up_done = d2; e.up_tc = mterm(m_up, u, pd3);
    e.ar_cnt = m_ar; e.ar_done = d3; e.ar_tc = mterm(m_ar, u, pd2);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    drive(1, 0, 0, 0, 0, 8'h12, 12'h105);
    e = sb.pop_front();
    checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL reset_count: got %h expected %h", dn_count, int2bcd(e.dn_cnt)); end
    checks++; if (dn_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", dn_done); end
    checks++; if (dn_tc !== e.dn_tc) begin errors++; $display("FAIL reset_tc: got %b expected %b", dn_tc, e.dn_tc); end
    checks++; if (dn_warn !== 1'b0) begin errors++; $display("FAIL reset_warn: got %b expected 0", dn_warn); end
    checks++; if ({20'h0, up_count} !== int2bcd(e.up_cnt)) begin errors++; $display("FAIL reset_up_count: got %h expected %h", up_count, int2bcd(e.up_cnt)); end
    checks++; if (ar_warn !== 1'b0) begin errors++; $display("FAIL reset_ar_warn: got %b expected 0", ar_warn); end
  endtask

  task automatic test_down_count();
    exp_t e;
    int pulses = 0;
    drive(0, 0, 1, 1, 0, 8'h12, 12'h105);
    e = sb.pop_front();
    checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL down_load: got %h expected %h", dn_count, int2bcd(e.dn_cnt)); end
    for (int k = 1; k <= 13; k++) begin
      drive(0, 1, 1, 0, 0, 8'h12, 12'h105);
      e = sb.pop_front();
      if (dn_done === 1'b1) pulses++;
      checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL down_count tick %0d: got %h expected %h", k, dn_count, int2bcd(e.dn_cnt)); end
      checks++; if (dn_done !== e.dn_done) begin errors++; $display("FAIL down_done tick %0d: got %b expected %b", k, dn_done, e.dn_done); end
      checks++; if (dn_tc !== e.dn_tc) begin errors++; $display("FAIL down_tc tick %0d: got %b expected %b", k, dn_tc, e.dn_tc); end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL down_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_up_count();
    exp_t e;
    int pulses = 0, at = -1;
    drive(0, 0, 1, 1, 1, 8'h99, 12'h105);
    e = sb.pop_front();
    checks++; if ({20'h0, up_count} !== int2bcd(e.up_cnt)) begin errors++; $display("FAIL up_load: got %h expected %h", up_count, int2bcd(e.up_cnt)); end
    for (int k = 1; k <= 108; k++) begin
      drive(0, 1, 1, 0, 1, 8'h99, 12'h105);
      e = sb.pop_front();
      if (up_done === 1'b1) begin pulses++; at = k; end
      checks++; if ({20'h0, up_count} !== int2bcd(e.up_cnt)) begin errors++; $display("FAIL up_count tick %0d: got %h expected %h", k, up_count, int2bcd(e.up_cnt)); end
      checks++; if (up_done !== e.up_done) begin errors++; $display("FAIL up_done tick %0d: got %b expected %b", k, up_done, e.up_done); end
      checks++; if (up_tc !== e.up_tc) begin errors++; $display("FAIL up_tc tick %0d: got %b expected %b", k, up_tc, e.up_tc); end
      checks++; if (up_warn !== 1'b0) begin errors++; $display("FAIL up_warn tick %0d: got %b expected 0", k, up_warn); end
    end
    checks++; if (pulses !== 1 || at !== 105) begin errors++; $display("FAIL up_pulses: got %0d at tick %0d expected 1 at tick 105", pulses, at); end
  endtask

  task automatic test_preset_move();
    exp_t e;
    drive(0, 0, 1, 1, 1, 8'h99, 12'h105);
    void'(sb.pop_front());
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 1, 0, 1, 8'h99, 12'h105);
      void'(sb.pop_front());
    end
    // Lower the limit below the current count: tc rises at once, but no done is generated.
    drive(0, 0, 1, 0, 1, 8'h99, 12'h003);
    e = sb.pop_front();
    checks++; if (up_tc !== e.up_tc) begin errors++; $display("FAIL move_tc: got %b expected %b", up_tc, e.up_tc); end
    checks++; if (up_done !== e.up_done) begin errors++; $display("FAIL move_done: got %b expected %b", up_done, e.up_done); end
    drive(0, 1, 1, 0, 1, 8'h99, 12'h003);
    e = sb.pop_front();
    checks++; if ({20'h0, up_count} !== int2bcd(e.up_cnt)) begin errors++; $display("FAIL move_hold: got %h expected %h", up_count, int2bcd(e.up_cnt)); end
    checks++; if (up_done !== e.up_done) begin errors++; $display("FAIL move_hold_done: got %b expected %b", up_done, e.up_done); end
  endtask

  task automatic test_auto_reload();
    exp_t e;
    int first = -1, second = -1;
    drive(0, 0, 1, 1, 0, 8'h03, 12'h105);
    void'(sb.pop_front());
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1, 1, 0, 0, 8'h03, 12'h105);
      e = sb.pop_front();
      if (ar_done === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      checks++; if ({24'h0, ar_count} !== int2bcd(e.ar_cnt)) begin errors++; $display("FAIL ar_count tick %0d: got %h expected %h", k, ar_count, int2bcd(e.ar_cnt)); end
      checks++; if (ar_done !== e.ar_done) begin errors++; $display("FAIL ar_done tick %0d: got %b expected %b", k, ar_done, e.ar_done); end
      checks++; if (ar_tc !== e.ar_tc) begin errors++; $display("FAIL ar_tc tick %0d: got %b expected %b", k, ar_tc, e.ar_tc); end
    end
    checks++; if (second - first !== 4) begin errors++; $display("FAIL ar_period: got %0d expected 4", second - first); end
    // Reload value of 0 is itself terminal: hold at 00 and pulse done on every step.
    drive(0, 0, 1, 1, 0, 8'h00, 12'h105);
    void'(sb.pop_front());
    for (int k = 1; k <= 3; k++) begin
      drive(0, 1, 1, 0, 0, 8'h00, 12'h105);
      e = sb.pop_front();
      checks++; if ({24'h0, ar_count} !== int2bcd(e.ar_cnt) || ar_done !== e.ar_done) begin errors++; $display("FAIL ar_zero tick %0d: got %h/%b expected %h/%b", k, ar_count, ar_done, int2bcd(e.ar_cnt), e.ar_done); end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    drive(0, 1, 1, 1, 0, 8'h45, 12'h105);
    e = sb.pop_front();
    checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt) || dn_done !== 1'b0) begin errors++; $display("FAIL prio_load_tick: got %h/%b expected %h/0", dn_count, dn_done, int2bcd(e.dn_cnt)); end
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0, 0, 8'h45, 12'h105);
      e = sb.pop_front();
      checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt) || dn_done !== 1'b0) begin errors++; $display("FAIL prio_pause %0d: got %h/%b expected %h/0", k, dn_count, dn_done, int2bcd(e.dn_cnt)); end
    end
    drive(0, 0, 1, 1, 0, 8'hA7, 12'h105);
    e = sb.pop_front();
    checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL prio_clamp: got %h expected %h", dn_count, int2bcd(e.dn_cnt)); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 8'hA7, 12'h105);
      e = sb.pop_front();
      checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL prio_clamp_step %0d: got %h expected %h", k, dn_count, int2bcd(e.dn_cnt)); end
    end
    drive(1, 1, 1, 0, 0, 8'hA7, 12'h105);
    e = sb.pop_front();
    checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt) || dn_done !== 1'b0) begin errors++; $display("FAIL prio_reset: got %h/%b expected %h/0", dn_count, dn_done, int2bcd(e.dn_cnt)); end
  endtask

  task automatic test_warn();
    exp_t e;
    drive(0, 0, 1, 1, 0, 8'h15, 12'h105);
    e = sb.pop_front();
    checks++; if (dn_warn !== e.dn_warn) begin errors++; $display("FAIL warn_load: got %b expected %b", dn_warn, e.dn_warn); end
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 1, 0, 0, 8'h15, 12'h105);
      e = sb.pop_front();
      checks++; if (dn_warn !== e.dn_warn) begin errors++; $display("FAIL warn tick %0d count %h: got %b expected %b", k, dn_count, dn_warn, e.dn_warn); end
      checks++; if ({24'h0, dn_count} !== int2bcd(e.dn_cnt)) begin errors++; $display("FAIL warn_count tick %0d: got %h expected %h", k, dn_count, int2bcd(e.dn_cnt)); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; tick = 0; run = 0; load = 0; up = 0; preset2 = '0; preset3 = '0;
    @(negedge clk);
    test_reset();
    test_down_count();
    test_up_count();
    test_preset_move();
    test_auto_reload();
    test_priority();
    test_warn();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
